// File: rtl/apb_engine_launcher.sv
// APB requester that programs one AIDC Lite engine (SRC/DST/LEN/START) and polls STATUS.
// Optional: define APB_LAUNCHER_SLVERR_ABORT_EN to abort a job on pslverr_i.
module apb_engine_launcher #(
   parameter int POLL_GAP = 100,
   parameter int POLL_MAX = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_src_i,
   input  logic [31:0] req_dst_i,
   input  logic [31:0] req_len_i,
   output logic        resp_valid_o,
   output logic [1:0]  resp_status_o,
   output logic        busy_o,
   output logic [31:0] paddr_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [31:0] pwdata_o,
   input  logic [31:0] prdata_i,
   input  logic        pready_i,
   input  logic        pslverr_i
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   localparam logic [1:0] ST_DONE = 2'b00;
   localparam logic [1:0] ST_ERR  = 2'b01;
   localparam logic [1:0] ST_TMO  = 2'b10;

   localparam logic [2:0] STEP_READ = 3'd4;

   localparam int PW = $clog2(POLL_MAX + 1);
   localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

   logic [2:0]    state;
   logic [2:0]    step;
   logic [PW-1:0] poll_cnt;
   logic [GW-1:0] gap_cnt;
   logic [31:0]   src_q;
   logic [31:0]   dst_q;
   logic [31:0]   len_q;
   logic [1:0]    status_q;

   logic        apb_err;
   logic        status_ok;
   logic        poll_last;
   logic        gap_last;
   logic [31:0] step_addr;
   logic [31:0] step_data;

`ifdef APB_LAUNCHER_SLVERR_ABORT_EN
   assign apb_err = pslverr_i;
`else
   logic unused_slverr;
   assign unused_slverr = pslverr_i;
   assign apb_err = 1'b0;
`endif

   assign status_ok = (prdata_i == 32'h1);
   assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));
   assign gap_last  = (gap_cnt == GW'(POLL_GAP - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         step     <= '0;
         poll_cnt <= '0;
         gap_cnt  <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         status_q <= ST_DONE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  src_q    <= req_src_i;
                  dst_q    <= req_dst_i;
                  len_q    <= req_len_i;
                  step     <= '0;
                  poll_cnt <= '0;
                  state    <= S_SETUP;
               end
            end
            S_SETUP: state <= S_ACCESS;
            S_ACCESS: begin
               if (pready_i) begin
                  if (apb_err) begin
                     status_q <= ST_ERR;
                     state    <= S_RESP;
                  end else if (step != STEP_READ) begin
                     step  <= step + 3'd1;
                     state <= S_SETUP;
                  end else if (status_ok) begin
                     status_q <= ST_DONE;
                     state    <= S_RESP;
                  end else if (poll_last) begin
                     status_q <= ST_TMO;
                     state    <= S_RESP;
                  end else begin
                     poll_cnt <= poll_cnt + PW'(1);
                     gap_cnt  <= '0;
                     state    <= (POLL_GAP == 0) ? S_SETUP : S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (gap_last) state <= S_SETUP;
               else gap_cnt <= gap_cnt + GW'(1);
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      step_addr = 32'h20;
      step_data = '0;
      unique case (step)
         3'd0: begin step_addr = 32'h10; step_data = src_q; end
         3'd1: begin step_addr = 32'h14; step_data = dst_q; end
         3'd2: begin step_addr = 32'h18; step_data = len_q; end
         3'd3: begin step_addr = 32'h1C; step_data = 32'd1; end
         default: begin
            step_addr = 32'h20;
            step_data = '0;
         end
      endcase
   end

   // APB outputs decode straight from state registers, so reset drops them at once
   assign psel_o        = (state == S_SETUP) || (state == S_ACCESS);
   assign penable_o     = (state == S_ACCESS);
   assign pwrite_o      = psel_o && (step != STEP_READ);
   assign paddr_o       = psel_o ? step_addr : '0;
   assign pwdata_o      = pwrite_o ? step_data : '0;
   assign req_ready_o   = (state == S_IDLE);
   assign resp_valid_o  = (state == S_RESP);
   assign resp_status_o = resp_valid_o ? status_q : 2'b00;
   assign busy_o        = (state != S_IDLE);

endmodule
